// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: one-cycle push strobes are queued in a FIFO
// and sent LSB first, back to back, on a registered idle-high serial line.
module uart_tx_buffered #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_ready,
    input  logic [7:0]            sdata,
    output logic                  txd,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned CNTW  = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr, rptr;
    logic [CW-1:0]           cyc;
    logic [2:0]              bit_idx;
    logic [7:0]              shift;
    logic                    push, pop, bit_end;

    // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue a push.
    assign push    = tx_ready && (count < CNTW'(DEPTH));
    assign bit_end = (cyc == CW'(CLK_PER_BIT - 1));
    assign busy    = (state != IDLE) || (count != '0);

    // Next-state and pop decision
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            if (tx_ready && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) mem[wptr] <= sdata;
    end

    // Serializer datapath: bit timing, shift register and line driver
    always_ff @(posedge clk) begin
        if (!rstn) begin
            txd     <= 1'b1;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            cyc <= ((state == IDLE) || bit_end) ? '0 : cyc + CW'(1);
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rptr];
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd     <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end && pop) begin
                        shift <= mem[rptr];
                        txd   <= 1'b0;
                    end
                end
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule
